tt_pbus_responder: RTL

TT_PBUS_RESPONDER -- requirements
Module: tt_pbus_responder

---
 rtl/tt_pbus_pkg.sv | 36 +++
 rtl/tt_sync2.sv | 25 ++
 rtl/tt_pbus_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tt_pbus_pkg.sv
// tt_pbus_pkg: shared types and constants for the parallel-bus register responder.
// Holds the FSM state encoding, address width, ui_in bit positions and the read-error value.
package tt_pbus_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   // ui_in bit positions of the host control fields
   localparam int STB_BIT  = 0;
   localparam int RNW_BIT  = 1;
   localparam int ADDR_LSB = 2;
   localparam int PAR_BIT  = 5;
   localparam int CTRL_W   = PAR_BIT + 1;

   // uo_out status bit positions
   localparam int ACK_BIT  = 0;
   localparam int ERR_BIT  = 1;
   localparam int BUSY_BIT = 2;

   // Value returned by a read that cannot be served
   localparam logic [DATA_W-1:0] RD_ERR_VAL = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_ACK,
      ST_WAIT_LOW
   } state_t;

   // Odd parity bit: the covered bits plus the returned bit hold an odd number of ones
   function automatic logic odd_par(input logic rnw, input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] data);
      return ~(^{rnw, addr, data});
   endfunction

endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: two-flop synchronizer for a bus of independent asynchronous bits.
module tt_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture; both stages clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking assignments make both stages sample the old values, giving two real flop stages.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/tt_pbus_responder.sv
// tt_pbus_responder: strobe-handshake register responder on the TinyTapeout pin set.
// The host raises stb with rnw/addr/(par)/data; the block acks four clocks later and holds
// ack until stb drops. Optional macro TT_PBUS_PARITY_EN enables odd-parity checking of
// {rnw, addr, write data or 8'h00} against ui_in[5].
module tt_pbus_responder
   import tt_pbus_pkg::*;
#(
   parameter int          NREGS     = 8,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam int                IDX_W   = $clog2(NREGS);
   localparam logic [ADDR_W:0]   NREGS_V = (ADDR_W + 1)'(NREGS);

   // Synchronized host control
   logic [CTRL_W-1:0] ctrl_s;
   logic              stb_s;
   logic              rnw_s;
   logic [ADDR_W-1:0] addr_s;
   logic [IDX_W-1:0]  idx;

   // Strobe edge detection
   logic [1:0]        warm;
   logic              stb_prev;
   logic              stb_rise;

   // FSM
   state_t            state, state_nx;

   // Transaction datapath
   logic              addr_bad;
   logic              par_bad;
   logic              txn_bad;
   logic              do_write;
   logic [DATA_W-1:0] regs [NREGS];
   logic              rnw_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ack;
   logic              busy;
   logic              drive_rd;
   logic              unused_ok;

   tt_sync2 #(.WIDTH(CTRL_W)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ui_in[CTRL_W-1:0]),
      .q     (ctrl_s)
   );

   assign stb_s  = ctrl_s[STB_BIT];
   assign rnw_s  = ctrl_s[RNW_BIT];
   assign addr_s = ctrl_s[ADDR_LSB +: ADDR_W];
   assign idx    = addr_s[IDX_W-1:0];

   // Previous synchronized stb. It is forced high until the synchronizer has flushed after
   // reset, so a strobe already high at release never looks like a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm     <= 2'b00;
         stb_prev <= 1'b1;
      end else begin
         warm     <= {warm[0], 1'b1};
         stb_prev <= warm[1] ? stb_s : 1'b1;
      end
   end

   assign stb_rise = stb_s & ~stb_prev;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
      state_nx = state;
      unique case (state)
         ST_IDLE:     if (stb_rise && ena) state_nx = ST_CAPTURE;
         ST_CAPTURE:  state_nx = ST_ACK;
         ST_ACK:      if (!stb_s) state_nx = ST_WAIT_LOW;
         ST_WAIT_LOW: state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   // Transaction validity: address range and, when enabled, host parity
   assign addr_bad = {1'b0, addr_s} >= NREGS_V;
`ifdef TT_PBUS_PARITY_EN
   assign par_bad   = ctrl_s[PAR_BIT] != odd_par(rnw_s, addr_s, rnw_s ? 8'h00 : uio_in);
   assign unused_ok = &{1'b0, ui_in[7:6]};
`else
   assign par_bad   = 1'b0;
   assign unused_ok = &{1'b0, ui_in[7:6], ctrl_s[PAR_BIT]};
`endif
   assign txn_bad  = addr_bad | par_bad;
   assign do_write = (state == ST_CAPTURE) && !rnw_s && !txn_bad;

   // Register file; writes land on the edge that leaves CAPTURE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the file is small and has a defined reset value, so every entry is reset; large RAMs would not be.
         for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      end else if (do_write) begin
         regs[idx] <= uio_in;
      end
   end

   // Response capture: direction, error flag and read data held for the ACK phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnw_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else if (state == ST_CAPTURE) begin
         rnw_q   <= rnw_s;
         err_q   <= txn_bad;
         rdata_q <= !rnw_s ? 8'h00 : (txn_bad ? RD_ERR_VAL : regs[idx]);
      end else if (state_nx == ST_IDLE) begin
         err_q   <= 1'b0;
      end
   end

   assign ack      = (state == ST_ACK);
   assign busy     = (state != ST_IDLE);
   assign drive_rd = ack && rnw_q;

   assign uio_out = drive_rd ? rdata_q : 8'h00;
   assign uio_oe  = drive_rd ? 8'hFF : 8'h00;

   always_comb begin
      uo_out           = {regs[0][4:0], 3'b000};
      uo_out[ACK_BIT]  = ack;
      uo_out[ERR_BIT]  = err_q;
      uo_out[BUSY_BIT] = busy;
   end

endmodule
